// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Brief    : Iterative multiply/divide sequencer owning the HI/LO pair.
//            Divider datapath present only when MDU_DIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] C_OP_MULT  = 3'b000;
    localparam logic [2:0] C_OP_MULTU = 3'b001;
    localparam logic [2:0] C_OP_DIV   = 3'b010;
    localparam logic [2:0] C_OP_DIVU  = 3'b011;
    localparam logic [2:0] C_OP_MTHI  = 3'b100;
    localparam logic [2:0] C_OP_MTLO  = 3'b101;

    localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_neg;
    logic [WIDTH-1:0]   r_m;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_mul_op;
    logic               w_arith;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // ---------------------------------------------------------------- decode
    assign w_mul_op = (op == C_OP_MULT) || (op == C_OP_MULTU);
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & src_a[WIDTH-1];
    assign w_b_neg  = w_signed & src_b[WIDTH-1];
    assign w_mag_b  = w_b_neg ? -src_b : src_b;

`ifdef MDU_DIV_EN
    logic               r_is_div;
    logic               r_neg_rem;
    logic               w_div_op;
    logic               w_dz;
    logic               w_neg_rem;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_new;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_div_op  = (op == C_OP_DIV) || (op == C_OP_DIVU);
    assign w_dz      = (src_b == '0);
    assign w_arith   = w_mul_op | w_div_op;
    // A zero divisor runs unsigned on the raw dividend so HI ends up as src_a.
    assign w_mag_a   = (w_a_neg && !(w_div_op && w_dz)) ? -src_a : src_a;
    assign w_neg     = (w_a_neg ^ w_b_neg) & ~(w_div_op & w_dz);
    assign w_neg_rem = w_a_neg & ~w_dz;

    // Restoring step: remainder in the upper half, dividend/quotient below.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_qbit    = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_new = w_qbit ? (w_rem_sh[WIDTH-1:0] - r_m) : w_rem_sh[WIDTH-1:0];
    assign w_step    = r_is_div ? {w_rem_new, r_acc[WIDTH-2:0], w_qbit} : w_mul_next;

    assign w_quo     = r_neg     ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
    assign w_rem     = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_res_hi  = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo  = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (r_state == S_IDLE && start && !flush && !r_busy && w_arith) begin
            r_is_div  <= w_div_op;
            r_neg_rem <= w_neg_rem & w_div_op;
        end
    end
`else
    assign w_arith  = w_mul_op;
    assign w_mag_a  = w_a_neg ? -src_a : src_a;
    assign w_neg    = w_a_neg ^ w_b_neg;
    assign w_step   = w_mul_next;
    assign w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = w_prod[WIDTH-1:0];
`endif

    // Shift-add step: multiplier in the low half, partial product above.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_m & {WIDTH{r_acc[0]}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -r_acc : r_acc;

    // ---------------------------------------------------------------- sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_m     <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !r_busy) begin
                            if (w_arith) begin
                                r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                                r_m     <= w_mag_b;
                                r_neg   <= w_neg;
                                r_cnt   <= C_CNT_INIT;
                                r_busy  <= 1'b1;
                                r_state <= S_CALC;
                            end else if (op == C_OP_MTHI) begin
                                r_hi <= src_a;
                            end else if (op == C_OP_MTLO) begin
                                r_lo <= src_a;
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - C_CNT_LAST;
                        if (r_cnt == C_CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
